// File: rtl/ps2_scan_controller.sv
// ps2_scan_controller: PS/2 keyboard receiver with prefix folding and scan-code FIFO.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2KeyboardClk,
  input  logic       PS2KeyboardData,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_break,
  input  logic       scan_ack,
  input  logic       clr_err,
  output logic       frame_err,
  output logic       overflow,
  output logic [7:0] led
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;

  logic          r_clk_s1, r_clk_s2, r_clk_hist, r_dat_s1, r_dat_s2;
  logic [1:0]    r_state;
  logic [2:0]    r_bitcnt;
  logic [7:0]    r_shift;
  logic          r_par, r_ext, r_brk;
  logic [WW-1:0] r_wd;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;

  logic w_fall, w_timeout, w_par_ok, w_stop, w_acc, w_bad, w_push, w_pop, w_full, w_wr, w_ovf;

  assign w_fall    = r_clk_hist & ~r_clk_s2;
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_wd == WW'(TIMEOUT_CYCLES - 1));
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok  = ^{r_shift, r_par};
`else
  assign w_par_ok  = r_par | 1'b1;
`endif
  assign w_stop    = (r_state == STOP) && w_fall;
  assign w_acc     = w_stop && r_dat_s2 && w_par_ok;
  assign w_bad     = (w_stop && !(r_dat_s2 && w_par_ok)) || w_timeout;
  assign w_push    = w_acc && (r_shift != 8'hE0) && (r_shift != 8'hF0);
  assign w_pop     = scan_ack && (r_cnt != '0);
  assign w_full    = r_cnt == (AW+1)'(FIFO_DEPTH);
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovf     = w_push && w_full && !w_pop;

  assign scan_valid = r_cnt != '0;
  assign {scan_ext, scan_break, scan_code} = r_mem[r_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_clk_s1, r_clk_s2, r_clk_hist, r_dat_s1, r_dat_s2} <= 5'b11111;
      r_state   <= IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_ext     <= 1'b0;
      r_brk     <= 1'b0;
      r_wd      <= '0;
      r_wr      <= '0;
      r_rd      <= '0;
      r_cnt     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      led       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_clk_s1   <= PS2KeyboardClk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= PS2KeyboardData;
      r_dat_s2   <= r_dat_s1;
      r_wd       <= (r_state == IDLE || w_fall || w_timeout) ? '0 : r_wd + 1'b1;
      if (w_timeout) begin
        r_state  <= IDLE;
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else if (w_fall) begin
        if (r_state == IDLE) begin
          if (!r_dat_s2) begin
            r_state  <= DATA;
            r_bitcnt <= '0;
          end
        end else if (r_state == DATA) begin
          r_shift  <= {r_dat_s2, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) r_state <= PARITY;
        end else if (r_state == PARITY) begin
          r_par   <= r_dat_s2;
          r_state <= STOP;
        end else begin
          r_state <= IDLE;
        end
      end
      if (w_acc) begin
        if (r_shift == 8'hE0) r_ext <= 1'b1;
        else if (r_shift == 8'hF0) r_brk <= 1'b1;
        else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end
      end
      if (w_push && !r_brk) led <= r_shift;
      if (w_wr) begin
        r_mem[r_wr] <= {r_ext, r_brk, r_shift};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt     <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      frame_err <= w_bad ? 1'b1 : clr_err ? 1'b0 : frame_err;
      overflow  <= w_ovf ? 1'b1 : clr_err ? 1'b0 : overflow;
    end
  end
endmodule

// File: tb/tb_ps2_scan_controller.sv
// tb_ps2_scan_controller: directed PS/2 frames with a scoreboard of expected FIFO entries.
module tb_ps2_scan_controller;
  localparam int H = 8;
  logic clk = 0, reset = 1, ps2_clk = 1, ps2_dat = 1, scan_ack = 0, clr_err = 0;
  logic scan_valid, scan_ext, scan_break, frame_err, overflow;
  logic [7:0] scan_code, led;
  logic [9:0] sb[$];
  int n_chk = 0, n_fail = 0;

  ps2_scan_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(200)) dut (
    .clk(clk), .reset(reset), .PS2KeyboardClk(ps2_clk), .PS2KeyboardData(ps2_dat),
    .scan_valid(scan_valid), .scan_code(scan_code), .scan_ext(scan_ext), .scan_break(scan_break),
    .scan_ack(scan_ack), .clr_err(clr_err), .frame_err(frame_err), .overflow(overflow), .led(led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (H) @(negedge clk);
    ps2_clk = 0;
    repeat (H) @(negedge clk);
    ps2_clk = 1;
  endtask

  task automatic send(input logic [7:0] d, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ bad_par);
    ps2_bit(1'b1);
    repeat (H) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    int t = 0;
    while (!scan_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : 10'h3ff;
    check({tag, "_valid"}, scan_valid, 1);
    check({tag, "_entry"}, {scan_ext, scan_break, scan_code}, e);
    scan_ack = 1;
    @(negedge clk);
    scan_ack = 0;
  endtask

  task automatic pulse_clr();
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", scan_valid, 0);
    check("rst_code", scan_code, 0);
    check("rst_ext_brk", {scan_ext, scan_break}, 0);
    check("rst_errs", {frame_err, overflow}, 0);
    check("rst_led", led, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    send(8'h1C, 0); sb.push_back({2'b00, 8'h1C});
    check("make_led", led, 8'h1C);
    pop_check("make");
    check("make_empty", scan_valid, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0); sb.push_back({2'b11, 8'h75});
    check("pfx_led", led, 8'h1C);
    pop_check("pfx");
    check("pfx_empty", scan_valid, 0);
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), 0);
      if (i <= 4) sb.push_back({2'b00, 8'(i)});
    end
    check("ovf_set", overflow, 1);
    check("ovf_led", led, 8'h06);
    check("ovf_ferr", frame_err, 0);
    for (int i = 0; i < 4; i++) pop_check("fifo");
    check("fifo_empty", scan_valid, 0);
    pulse_clr();
    check("ovf_clr", overflow, 0);
    send(8'h1C, 1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_ferr", frame_err, 1);
    check("par_valid", scan_valid, 0);
`else
    sb.push_back({2'b00, 8'h1C});
    check("par_ferr", frame_err, 0);
    pop_check("par");
`endif
    pulse_clr();
    check("par_clr", frame_err, 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (260) @(negedge clk);
    check("to_ferr", frame_err, 1);
    check("to_valid", scan_valid, 0);
    pulse_clr();
    check("to_clr", frame_err, 0);
    send(8'h2A, 0); sb.push_back({2'b00, 8'h2A});
    pop_check("to_next");
    send(8'h11, 0); send(8'h22, 0);
    check("pre_rst_valid", scan_valid, 1);
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    reset = 1;
    @(negedge clk);
    check("mid_rst_valid", scan_valid, 0);
    check("mid_rst_outs", {scan_code, scan_ext, scan_break, frame_err, overflow, led}, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    send(8'h33, 0); sb.push_back({2'b00, 8'h33});
    pop_check("post_rst");
    check("post_rst_empty", scan_valid, 0);
    check("post_rst_led", led, 8'h33);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_scan_controller.md
# ps2_scan_controller

Sequences the PS/2 keyboard receive path in the system clock domain: it synchronizes the keyboard's clock and data lines, frames each 11-bit PS/2 packet and folds the 0xE0 and 0xF0 prefix bytes into flags on the following code. Completed scan codes are queued in a small FIFO and handed to the memory controller over a valid/ack handshake. The block sits between the PS/2 pins and the memory controller, and also drives the board LEDs with the last make code.

## Interface
- FIFO_DEPTH, 4: number of queued scan-code entries; must be a power of two, minimum 2.
- TIMEOUT_CYCLES, 50000: clk cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.
- clk  input  1  system clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- PS2KeyboardClk  input  1  raw PS/2 clock from the keyboard; asynchronous to clk.
- PS2KeyboardData  input  1  raw PS/2 data from the keyboard; asynchronous to clk.
- scan_valid  output  1  FIFO head entry is available.
- scan_code  output  8  head entry: scan code byte.
- scan_ext  output  1  head entry: code was preceded by 0xE0.
- scan_break  output  1  head entry: code was preceded by 0xF0 (key release).
- scan_ack  input  1  memory controller consumes the head entry.
- clr_err  input  1  clears the sticky error flags.
- frame_err  output  1  sticky: stop-bit, parity or timeout error seen.
- overflow  output  1  sticky: an entry was dropped because the FIFO was full.
- led  output  8  last accepted make code (entries with break=0).

## Operation
- Synchronizer: two flops per PS/2 line, then one history flop on the clock line. fall = (history==1 && synced clock==0) is a one-cycle pulse.
- Frame FSM; all state advances only on fall:
  - IDLE: if synced data==0 (start bit), go to DATA with bitcnt=0; if data==1, stay in IDLE.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: accept the frame if data==1 (and parity passes, see Configuration); otherwise set frame_err and discard the frame. Always return to IDLE.
- Watchdog: counts clk cycles since the last fall in any state other than IDLE. On reaching TIMEOUT_CYCLES: go to IDLE, discard the partial byte, set frame_err. The prefix flags are kept.
- Prefix decoder, applied to each accepted byte:
  - 0xE0 sets the pending ext flag; no push.
  - 0xF0 sets the pending break flag; no push.
  - Any other byte pushes {ext, break, byte} and then clears both pending flags.
- FIFO behaviour:
  - Push when full drops the new entry and sets overflow; the pending flags are still cleared.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted with no overflow.
  - Pointers wrap modulo FIFO_DEPTH; occupancy is tracked with a counter of width log2(FIFO_DEPTH)+1.
- Handshake:
  - scan_valid = FIFO not empty.
  - scan_code, scan_ext and scan_break show the head entry and are stable while scan_valid=1 and scan_ack=0.
  - scan_ack with scan_valid=1 pops at that edge; scan_ack while empty is ignored.
- led loads the byte on every accepted push with break=0, independent of FIFO fullness.
- clr_err clears frame_err and overflow. If an error event occurs in the same cycle, the event wins and the flag stays 1.

## Timing
- Reset values: FSM=IDLE, bitcnt=0, shift register=0, pending flags=0, FIFO empty.
- Output reset values: scan_valid=0, scan_code=0, scan_ext=0, scan_break=0, frame_err=0, overflow=0, led=0.
- Reset asserted mid-frame aborts the frame; FIFO contents are lost.
- Latency: let edge N be the first clk rising edge at which sync stage 1 captures the stop bit's falling PS2KeyboardClk.
  - fall is high during cycle N+1.
  - The FSM accepts the frame and the FIFO is written at edge N+2.
  - scan_valid=1 is visible after edge N+2.
- Pop: after an ack at edge M, the next head entry (or scan_valid=0) is visible after edge M.
- Minimum PS/2 clock low/high time is several µs, far longer than 3 clk periods, so no fall is missed.

## Configuration
- PS2_PARITY_CHECK_EN defined: a frame is accepted only if the 8 data bits plus the parity bit contain an odd number of ones. A parity failure sets frame_err and discards the frame; the pending flags are unchanged.
- PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored. Only the stop bit and the watchdog can set frame_err.

## Test plan
- Frame 0x1C with correct parity and scan_ack held low -> scan_valid=1, scan_code=0x1C, scan_ext=0, scan_break=0, led=0x1C; pulse scan_ack -> scan_valid=0.
- Frames E0, F0, 0x75 -> exactly one entry: code=0x75, ext=1, break=1; led unchanged.
- FIFO_DEPTH=4, six frames 0x01..0x06 with no ack -> entries 0x01..0x04 kept, overflow=1. Then four acks return 0x01..0x04 in order; clr_err -> overflow=0.
- Frame 0x1C with a wrong parity bit -> with PS2_PARITY_CHECK_EN: no entry, frame_err=1; without it: entry 0x1C, frame_err=0.
- Stop PS2KeyboardClk after 4 data bits for TIMEOUT_CYCLES -> frame_err=1, FSM in IDLE, no entry; a following clean 0x2A frame is queued correctly.
- Assert reset in the middle of a frame while the FIFO holds 2 entries -> all outputs 0, scan_valid=0; the next full frame is received normally.
